// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port datapath register file: default sizing,
// PC placement and architectural register names.
package reg_file_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_PC_IDX = 15;
  localparam int DEF_PC_INC = 4;

  localparam int REG_SP = 13;
  localparam int REG_LR = 14;
  localparam int REG_PC = 15;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: register select mux with optional forwarding
// of same-cycle write data (port A has priority over port B).
module reg_file_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic              fwd_en_i,
  input  logic              wr_en_a_i,
  input  logic [ADDR_W-1:0] wr_addr_a_i,
  input  logic [DATA_W-1:0] wr_data_a_i,
  input  logic              wr_en_b_i,
  input  logic [ADDR_W-1:0] wr_addr_b_i,
  input  logic [DATA_W-1:0] wr_data_b_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic hit_a;
  logic hit_b;

  assign hit_a = (BYPASS != 0) && fwd_en_i && wr_en_a_i && (wr_addr_a_i == rd_addr_i);
  assign hit_b = (BYPASS != 0) && fwd_en_i && wr_en_b_i && (wr_addr_b_i == rd_addr_i);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    if (hit_a) begin
      rd_data_o = wr_data_a_i;
    end else if (hit_b) begin
      rd_data_o = wr_data_b_i;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NUM_RD read ports, two write ports (A beats B),
// auto-incrementing PC register and a registered same-target write flag.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int PC_INC = DEF_PC_INC,
  parameter int BYPASS = 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  input  logic                     WrEnA,
  input  logic [ADDR_W-1:0]        WrAddrA,
  input  logic [DATA_W-1:0]        WrDataA,
  input  logic                     WrEnB,
  input  logic [ADDR_W-1:0]        WrAddrB,
  input  logic [DATA_W-1:0]        WrDataB,
  input  logic                     PcInc,
  output logic [DATA_W-1:0]        PcOut,
  output logic                     WrConflict
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              conflict_q;
  logic              conflict_d;

  // Per-register next state; the priority chain also yields the PC ordering
  // (A write, then B write, then increment, then hold).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_next
    localparam bit IS_PC = (gi == PC_IDX);
    logic sel_a;
    logic sel_b;
    assign sel_a = WrEnA && (WrAddrA == ADDR_W'(gi));
    assign sel_b = WrEnB && (WrAddrB == ADDR_W'(gi));
    assign regs_d[gi] = sel_a            ? WrDataA :
                        sel_b            ? WrDataB :
                        (IS_PC && PcInc) ? regs_q[gi] + DATA_W'(PC_INC) :
                                           regs_q[gi];
  end

  assign conflict_d = WrEnA && WrEnB && (WrAddrA == WrAddrB);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      conflict_q <= conflict_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .BYPASS(BYPASS)
    ) u_rd (
      .rd_addr_i  (RdAddr[gi*ADDR_W +: ADDR_W]),
      .regs_i     (regs_q),
      .fwd_en_i   (Rst_n),
      .wr_en_a_i  (WrEnA),
      .wr_addr_a_i(WrAddrA),
      .wr_data_a_i(WrDataA),
      .wr_en_b_i  (WrEnB),
      .wr_addr_b_i(WrAddrB),
      .wr_data_b_i(WrDataB),
      .rd_data_o  (RdData[gi*DATA_W +: DATA_W])
    );
  end

  assign PcOut      = regs_q[PC_SEL];
  assign WrConflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one forwarding and one non-forwarding
// instance share the same stimulus; expectations are hand-computed.
module tb_reg_file_mp;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [11:0] RdAddr;
  logic        WrEnA, WrEnB, PcInc;
  logic [3:0]  WrAddrA, WrAddrB;
  logic [31:0] WrDataA, WrDataB;
  logic [95:0] rd_data_byp, rd_data_nob;
  logic [31:0] pc_byp, pc_nob;
  logic        cfl_byp, cfl_nob;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  reg_file_mp #(.BYPASS(1)) dut_byp (
    .Clk(Clk), .Rst_n(Rst_n), .RdAddr(RdAddr), .RdData(rd_data_byp),
    .WrEnA(WrEnA), .WrAddrA(WrAddrA), .WrDataA(WrDataA),
    .WrEnB(WrEnB), .WrAddrB(WrAddrB), .WrDataB(WrDataB),
    .PcInc(PcInc), .PcOut(pc_byp), .WrConflict(cfl_byp)
  );

  reg_file_mp #(.BYPASS(0)) dut_nob (
    .Clk(Clk), .Rst_n(Rst_n), .RdAddr(RdAddr), .RdData(rd_data_nob),
    .WrEnA(WrEnA), .WrAddrA(WrAddrA), .WrDataA(WrDataA),
    .WrEnB(WrEnB), .WrAddrB(WrAddrB), .WrDataB(WrDataB),
    .PcInc(PcInc), .PcOut(pc_nob), .WrConflict(cfl_nob)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] rd(input logic [95:0] bus, input int p);
    return bus[p*32 +: 32];
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    WrEnA = 1'b0; WrEnB = 1'b0; PcInc = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; RdAddr = '0;
    WrAddrA = '0; WrAddrB = '0; WrDataA = '0; WrDataB = '0;
    idle();
    step(); step();
    chk("rst_pc", pc_byp, 32'd0);
    chk("rst_cfl", {31'd0, cfl_byp}, 32'd0);
    chk("rst_rd0", rd(rd_data_byp, 0), 32'd0);
    Rst_n = 1'b1;

    // basic writes
    WrEnA = 1'b1; WrAddrA = 4'd0; WrDataA = 32'd100; step();
    WrAddrA = 4'd1; WrDataA = 32'd104; step();
    idle();
    RdAddr = {4'd2, 4'd1, 4'd0}; #1;
    chk("basic_p0", rd(rd_data_byp, 0), 32'd100);
    chk("basic_p1", rd(rd_data_byp, 1), 32'd104);
    chk("basic_p2", rd(rd_data_byp, 2), 32'd0);
    chk("basic_pc", pc_byp, 32'd0);

    // full sweep R0..R14 = 35+4k
    for (int k = 0; k < 15; k++) begin
      WrEnA = 1'b1; WrAddrA = 4'(k); WrDataA = 32'(35 + 4*k); step();
    end
    idle();
    for (int k = 0; k < 15; k++) begin
      RdAddr = {3{4'(k)}}; #1;
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("sweep_r%0d_p%0d", k, p), rd(rd_data_byp, p), 32'(35 + 4*k));
      end
    end

    // dual write, distinct then same target
    WrEnA = 1'b1; WrAddrA = 4'd3; WrDataA = 32'hAAAA0000;
    WrEnB = 1'b1; WrAddrB = 4'd4; WrDataB = 32'h00005555; step();
    chk("dual_cfl0", {31'd0, cfl_byp}, 32'd0);
    WrAddrA = 4'd5; WrDataA = 32'h11; WrAddrB = 4'd5; WrDataB = 32'h22; step();
    idle();
    chk("dual_cfl1", {31'd0, cfl_byp}, 32'd1);
    RdAddr = {4'd5, 4'd4, 4'd3}; #1;
    chk("dual_r3", rd(rd_data_byp, 0), 32'hAAAA0000);
    chk("dual_r4", rd(rd_data_byp, 1), 32'h00005555);
    chk("dual_r5", rd(rd_data_byp, 2), 32'h11);
    step();
    chk("dual_cfl_clr", {31'd0, cfl_byp}, 32'd0);

    // forwarding; R6 holds 35+24=59 from the sweep
    RdAddr = {4'd0, 4'd0, 4'd6};
    WrEnA = 1'b1; WrAddrA = 4'd6; WrDataA = 32'hDEAD; #1;
    chk("byp_fwd", rd(rd_data_byp, 0), 32'hDEAD);
    chk("nob_old", rd(rd_data_nob, 0), 32'd59);
    WrEnB = 1'b1; WrAddrB = 4'd6; WrDataB = 32'hBEEF; #1;
    chk("byp_a_over_b", rd(rd_data_byp, 0), 32'hDEAD);
    WrEnB = 1'b0;
    step();
    idle(); #1;
    chk("nob_after", rd(rd_data_nob, 0), 32'hDEAD);
    WrEnB = 1'b1; WrAddrB = 4'd6; WrDataB = 32'hBEEF; #1;
    chk("byp_fwd_b", rd(rd_data_byp, 0), 32'hBEEF);
    idle();

    // PC increment, read shows pre-increment value
    RdAddr = {4'd0, 4'd0, 4'd15};
    for (int i = 0; i < 5; i++) begin
      PcInc = 1'b1; #1;
      chk($sformatf("pc_pre%0d", i), rd(rd_data_byp, 0), 32'(4*i));
      step();
      chk($sformatf("pc_inc%0d", i), pc_byp, 32'(4*(i+1)));
    end
    WrEnB = 1'b1; WrAddrB = 4'd15; WrDataB = 32'h100; step();
    chk("pc_wrb", pc_byp, 32'h100);
    WrEnB = 1'b1; WrDataB = 32'h200; WrEnA = 1'b1; WrAddrA = 4'd15; WrDataA = 32'h300; step();
    chk("pc_a_over_b", pc_byp, 32'h300);
    WrEnB = 1'b0; WrEnA = 1'b1; WrDataA = 32'hFFFFFFFC; PcInc = 1'b0; step();
    WrEnA = 1'b0; PcInc = 1'b1; step();
    idle();
    chk("pc_wrap", pc_byp, 32'd0);

    // reset mid-operation; R7 holds 35+28=63
    RdAddr = {4'd0, 4'd0, 4'd7};
    WrEnA = 1'b1; WrAddrA = 4'd7; WrDataA = 32'h1234;
    WrEnB = 1'b1; WrAddrB = 4'd7; WrDataB = 32'h5678;
    PcInc = 1'b1; Rst_n = 1'b0; #1;
    chk("rst_nofwd", rd(rd_data_byp, 0), 32'd63);
    step();
    chk("rst_r7", rd(rd_data_byp, 0), 32'd0);
    chk("rst_pc2", pc_byp, 32'd0);
    chk("rst_cfl2", {31'd0, cfl_byp}, 32'd0);
    idle(); Rst_n = 1'b1; step();
    chk("post_rst_r7", rd(rd_data_byp, 0), 32'd0);
    chk("post_rst_pc", pc_byp, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
